half_duplex_bus_port: RTL

HALF_DUPLEX_BUS_PORT -- requirements
Module: half_duplex_bus_port

---
 rtl/half_duplex_bus_port.sv | 109 ++++++++++
 1 files changed

// File: rtl/half_duplex_bus_port.sv
// rtl/half_duplex_bus_port.sv - half-duplex tri-state bus port with turnaround gaps and receive priority.
// The bus enable, dir and tx_ack all come from the single registered drive flag.
module half_duplex_bus_port #(
  parameter int WIDTH = 8,
  parameter int TURN  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             tx_req,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ack,
  input  logic             rx_en,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             dir,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE,
    TURN_TX,
    DRIVE,
    TURN_RX,
    RECV
  } state_t;

  localparam logic [3:0] TURN_L = 4'(TURN);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nxt;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] word_nxt;
  logic             drive_q;
  logic             capture;
  logic             contention;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    word_nxt   = word;
    capture    = 1'b0;
    contention = 1'b0;
    case (state)
      IDLE: begin
        if (rx_en) begin
          // Receive wins; a pending tx_req is simply re-sampled later.
          state_nxt = RECV;
          capture   = 1'b1;
        end else if (tx_req) begin
          state_nxt = TURN_TX;
          word_nxt  = tx_data;
          cnt_nxt   = TURN_L;
        end
      end
      TURN_TX: begin
        if (rx_en) begin
          contention = 1'b1;
          state_nxt  = TURN_RX;
          cnt_nxt    = TURN_L;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        contention = rx_en;
        state_nxt  = TURN_RX;
        cnt_nxt    = TURN_L;
      end
      TURN_RX: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = IDLE;
      end
      RECV: begin
        if (rx_en) capture = 1'b1;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      word     <= '0;
      drive_q  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      word     <= word_nxt;
      drive_q  <= (state_nxt == DRIVE);
      rx_valid <= capture;
      err      <= contention;
      if (capture) rx_data <= bus;
    end
  end

  assign dir    = drive_q;
  assign tx_ack = drive_q;
  assign bus    = drive_q ? word : {WIDTH{1'bz}};

endmodule
